// File: rtl/ifu.sv
// -----------------------------------------------------------------------------
// ifu -- instruction fetch unit
//
// Fetches one instruction at a time from an instruction memory and hands it to
// the decode stage. It walks through REQ (issue the request), WAIT (collect the
// response) and OUT (present the instruction), then moves on to pc+4.
//
// A redirect pulse takes priority over everything else. It loads a new
// word-aligned pc and restarts at REQ. If a request is still in flight when
// the redirect arrives, its response is dropped.
//
// Optional feature (macro IFU_EBREAK_HALT_EN): when an ebreak (32'h0010_0073)
// is accepted by decode, fetch stops in HALT with halt=1. Only rst leaves
// HALT. Without the macro there is no HALT state and halt is tied to 0.
//
// Parameters:
//   RESET_PC        address of the first fetch after reset
// Ports:
//   clk             clock, all state changes on the rising edge
//   rst             synchronous active-high reset
//   imem_req_valid  fetch request valid (suppressed during a redirect)
//   imem_req_ready  memory accepts the request
//   imem_addr       fetch address (registered pc, word aligned)
//   imem_resp_valid fetch data valid
//   imem_resp_data  fetched instruction
//   out_valid       instruction valid to decode (suppressed during a redirect)
//   out_ready       decode accepts the instruction
//   out_inst        instruction to decode (registered)
//   out_pc          pc of out_inst (registered)
//   redirect_valid  one-cycle control-flow redirect
//   redirect_pc     redirect target (low two bits ignored)
//   halt            fetch stopped on ebreak
// -----------------------------------------------------------------------------
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halt
);

`ifdef IFU_EBREAK_HALT_EN
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_OUT  = 3'd3,
        S_HALT = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_OUT  = 3'd3
    } state_t;
`endif

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_drop;     // one stale response is still owed by memory
    logic        w_redirect_take;
    logic [31:0] w_redirect_pc;

    assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

`ifdef IFU_EBREAK_HALT_EN
    logic r_halt;
    assign w_redirect_take = redirect_valid && (r_state != S_HALT);
    assign halt            = r_halt;
`else
    assign w_redirect_take = redirect_valid;
    assign halt            = 1'b0;
`endif

    assign imem_addr = r_pc;
    assign out_pc    = r_pc;
    assign out_inst  = r_inst;

    // Handshake valids, squashed in any redirect cycle so the old path never handshakes.
    always_comb begin
        imem_req_valid = 1'b0;
        out_valid      = 1'b0;
        if (redirect_valid) begin
            imem_req_valid = 1'b0;
            out_valid      = 1'b0;
        end else begin
            imem_req_valid = (r_state == S_REQ);
            out_valid      = (r_state == S_OUT);
        end
    end

    // Fetch state machine, pc, instruction register and stale-response bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_inst  <= 32'h0000_0000;
            r_drop  <= 1'b0;
`ifdef IFU_EBREAK_HALT_EN
            r_halt  <= 1'b0;
`endif
        end else if (w_redirect_take) begin
            r_pc    <= w_redirect_pc;
            r_state <= S_REQ;
            // Leaving WAIT orphans the in-flight request, unless its own
            // response arrives in this very cycle (that one is discarded here).
            // A response seen with r_drop set is the previously orphaned one.
            if (r_state == S_WAIT) begin
                r_drop <= r_drop || !imem_resp_valid;
            end else if (imem_resp_valid) begin
                r_drop <= 1'b0;
            end else begin
                r_drop <= r_drop;
            end
        end else begin
            // Any response consumes the pending drop (or leaves it clear).
            if (imem_resp_valid) begin
                r_drop <= 1'b0;
            end else begin
                r_drop <= r_drop;
            end
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                end
                S_REQ: begin
                    if (imem_req_ready) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_state <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid && !r_drop) begin
                        r_inst  <= imem_resp_data;
                        r_state <= S_OUT;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_pc <= r_pc + 32'd4;
`ifdef IFU_EBREAK_HALT_EN
                        if (r_inst == EBREAK_INST) begin
                            r_state <= S_HALT;
                            r_halt  <= 1'b1;
                        end else begin
                            r_state <= S_REQ;
                        end
`else
                        r_state <= S_REQ;
`endif
                    end else begin
                        r_state <= S_OUT;
                    end
                end
`ifdef IFU_EBREAK_HALT_EN
                S_HALT: begin
                    r_state <= S_HALT;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu.sv
// -----------------------------------------------------------------------------
// tb_ifu -- self-checking bench for ifu
//
// The memory model answers each accepted request after mem_lat cycles with
// data derived from the address. The stream model tracks which pc decode must
// see next: it starts at RESET_PC, moves to pc+4 per accepted instruction and
// jumps to the aligned target on a redirect. Every cycle, the DUT outputs are
// checked against this model. Directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_ifu;
    localparam logic [31:0] RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] EBREAK_PC = 32'h8000_0200;
`ifdef IFU_EBREAK_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt;

    int n_vec = 0;
    int n_err = 0;

    ifu #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == EBREAK_PC) return 32'h0010_0073;
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory: fixed latency, in-order, survives rst ----------
    int          mem_lat = 1;
    int          cyc = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    always begin
        @(posedge clk);
        cyc++;
        if (imem_req_valid && imem_req_ready) begin
            pend_addr.push_back(imem_addr);
            pend_due.push_back(cyc + mem_lat - 1);
        end
        #1;
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_data(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
    end

    // ---------------- stream model -------------------------------------------
    logic [31:0] m_pc = RESET_PC;
    bit          m_halted = 1'b0;
    logic [31:0] log_pc[$];
    longint      log_t[$];

    always @(posedge clk) begin
        if (rst) begin
            m_pc     <= RESET_PC;
            m_halted <= 1'b0;
        end else if (!m_halted) begin
            if (redirect_valid) begin
                m_pc <= {redirect_pc[31:2], 2'b00};
            end else if (out_valid && out_ready) begin
                log_pc.push_back(out_pc);
                log_t.push_back($time);
                if (HALT_EN && out_inst == 32'h0010_0073) m_halted <= 1'b1;
                m_pc <= m_pc + 32'd4;
            end
        end
    end

    // ---------------- per-cycle compare --------------------------------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
            if (m_halted) begin
                chk1("halt_set", halt, 1'b1);
                chk1("halt_no_req", imem_req_valid, 1'b0);
                chk1("halt_no_out", out_valid, 1'b0);
            end else begin
                chk1("halt_clear", halt, 1'b0);
                if (imem_req_valid) chk("req_addr", imem_addr, m_pc);
                if (out_valid) begin
                    chk("out_pc", out_pc, m_pc);
                    chk("out_inst", out_inst, mem_data(m_pc));
                end
                if (redirect_valid) begin
                    chk1("redir_squash_req", imem_req_valid, 1'b0);
                    chk1("redir_squash_out", out_valid, 1'b0);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------------------------------
    // which: 0 = out_valid, 1 = imem_req_valid, 2 = request handshake
    task automatic wait_for(input int which, input string name);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < 100) begin
            @(negedge clk);
            n++;
            case (which)
                0:       hit = out_valid;
                1:       hit = imem_req_valid;
                2:       hit = imem_req_valid && imem_req_ready;
                default: hit = 1'b0;
            endcase
        end
        n_vec++;
        if (!hit) begin
            n_err++;
            $display("FAIL timeout_%s: event not seen within 100 cycles", name);
        end
    endtask

    task automatic wait_log(input int n, input string name);
        int k = 0;
        while (log_pc.size() < n && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (log_pc.size() < n) begin
            n_err++;
            $display("FAIL timeout_%s: %0d instructions delivered, need %0d", name, log_pc.size(), n);
        end
    endtask

    // call at posedge+#1; leaves at posedge+#1 with the pulse removed
    task automatic pulse_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    logic [31:0] cap_pc, cap_inst;
    int          base;

    initial begin
        // reset and first fetches, zero-wait memory
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk1("idle_req_valid", imem_req_valid, 1'b0);
        chk1("idle_out_valid", out_valid, 1'b0);
        chk("idle_out_inst", out_inst, 32'h0);
        chk("idle_out_pc", out_pc, 32'h8000_0000);
        chk("idle_imem_addr", imem_addr, 32'h8000_0000);
        chk1("halt_reset", halt, 1'b0);
        @(negedge clk);
        chk1("first_req_valid", imem_req_valid, 1'b1);
        chk("first_req_addr", imem_addr, 32'h8000_0000);
        wait_log(3, "first3");
        if (log_pc.size() >= 3) begin
            chk("seq_pc0", log_pc[0], 32'h8000_0000);
            chk("seq_pc1", log_pc[1], 32'h8000_0004);
            chk("seq_pc2", log_pc[2], 32'h8000_0008);
            chk("spacing01", 32'(log_t[1] - log_t[0]), 32'd30);
            chk("spacing12", 32'(log_t[2] - log_t[1]), 32'd30);
        end

        // decode stall for 5 cycles in OUT
        @(posedge clk); #1 out_ready = 1'b0;
        wait_for(0, "stall_out");
        cap_pc   = out_pc;
        cap_inst = out_inst;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("stall_valid", out_valid, 1'b1);
            chk("stall_pc", out_pc, cap_pc);
            chk("stall_inst", out_inst, cap_inst);
            chk1("stall_no_req", imem_req_valid, 1'b0);
        end
        @(posedge clk); #1 out_ready = 1'b1;

        // memory back-pressure on the request
        imem_req_ready = 1'b0;
        wait_for(1, "bp_req");
        cap_pc = imem_addr;
        repeat (3) begin
            @(negedge clk);
            chk1("bp_req_held", imem_req_valid, 1'b1);
            chk("bp_addr_held", imem_addr, cap_pc);
        end
        @(posedge clk); #1 imem_req_ready = 1'b1;

        // redirect in WAIT, stale response arrives two cycles later
        mem_lat = 3;
        wait_for(2, "hs_before_redir");
        @(posedge clk); #1;
        base = log_pc.size();
        pulse_redirect(32'h8000_0103);
        @(negedge clk);
        chk1("redir_req_valid", imem_req_valid, 1'b1);
        chk("redir_req_addr", imem_addr, 32'h8000_0100);
        wait_log(base + 1, "after_redir");
        if (log_pc.size() > base) chk("redir_first_out", log_pc[base], 32'h8000_0100);
        mem_lat = 1;

        // redirect while an instruction waits in OUT
        @(posedge clk); #1 out_ready = 1'b0;
        wait_for(0, "out_before_redir");
        @(posedge clk); #1;
        base = log_pc.size();
        pulse_redirect(32'h8000_0040);
        out_ready = 1'b1;
        wait_log(base + 1, "after_out_redir");
        if (log_pc.size() > base) chk("out_redir_first", log_pc[base], 32'h8000_0040);

        // pc wrap at the top of the address space
        @(posedge clk); #1;
        pulse_redirect(32'hFFFF_FFFE);
        wait_for(0, "wrap_out");
        chk("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
        wait_for(1, "wrap_req");
        chk("wrap_next_addr", imem_addr, 32'h0000_0000);

        // reset pulsed during WAIT, stale response must be ignored
        mem_lat = 3;
        wait_for(2, "hs_before_rst");
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        base = log_pc.size();
        wait_for(1, "req_after_rst");
        chk("rst_restart_addr", imem_addr, 32'h8000_0000);
        wait_log(base + 1, "after_rst");
        if (log_pc.size() > base) chk("rst_first_out", log_pc[base], 32'h8000_0000);
        mem_lat = 1;

        // ebreak handling
        @(posedge clk); #1;
        pulse_redirect(EBREAK_PC);
        wait_for(0, "ebreak_out");
        chk("ebreak_inst", out_inst, 32'h0010_0073);
        @(posedge clk); #1;
        if (HALT_EN) begin
            for (int i = 0; i < 20; i++) begin
                if (i == 5) pulse_redirect(32'h8000_0300);
                @(negedge clk);
                chk1("halted_flag", halt, 1'b1);
                chk1("halted_no_req", imem_req_valid, 1'b0);
            end
            @(posedge clk); #1 rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
            wait_for(1, "req_after_halt");
            chk("halt_exit_addr", imem_addr, 32'h8000_0000);
        end else begin
            wait_for(1, "req_after_ebreak");
            chk("ebreak_next_addr", imem_addr, 32'h8000_0204);
            chk1("ebreak_no_halt", halt, 1'b0);
        end

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
